// File: rtl/register_file.sv
// Multi-entry register bank: one synchronous write port, two combinational read ports, per-entry valid bitmap.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              valid_a,
    output logic              valid_b
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             wr_en_c;

    assign wr_en_c = load && ({1'b0, waddr} < DEPTH_L);

    // Storage update: clear first, then the write, so a written entry survives a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            if (clear) begin
                valid <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en_c && (waddr == ADDR_W'(i))) begin
                    mem[i]   <= in;
                    valid[i] <= 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_a_c;
    logic byp_b_c;

    assign byp_a_c = rst_n && wr_en_c && (raddr_a == waddr);
    assign byp_b_c = rst_n && wr_en_c && (raddr_b == waddr);
`endif

    // Port A read mux; out-of-range addresses match no entry and read as invalid
    always_comb begin
        out_a   = '0;
        valid_a = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((raddr_a == ADDR_W'(i)) && valid[i]) begin
                out_a   = mem[i];
                valid_a = 1'b1;
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_a_c) begin
            out_a   = in;
            valid_a = 1'b1;
        end
`endif
    end

    // Port B read mux
    always_comb begin
        out_b   = '0;
        valid_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((raddr_b == ADDR_W'(i)) && valid[i]) begin
                out_b   = mem[i];
                valid_b = 1'b1;
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_b_c) begin
            out_b   = in;
            valid_b = 1'b1;
        end
`endif
    end

endmodule
